// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and access sequencer in front of
// the byte-addressed data memory. Requester A is the pipeline MEM stage,
// requester B the loader/debug port. Every granted access runs
// IDLE/RESP -> ACCESS -> RESP. Accesses with an unsupported type or past the
// end of memory are rejected and never reach the memory.
//
// Build option: define DM_ARB_ALIGN_CHECK_EN to also reject misaligned half
// and word accesses. Without it, misaligned accesses go to memory unchanged.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no access in flight; arbitrate among raised requests
// ACCESS | drive dm_* from latched fields, capture read data (gnt high here)
// RESP   | rvalid/err for the owner; arbitrate again for back-to-back use
module dm_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_type,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [2:0]  b_type,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        dm_MemWrite,
  output logic        dm_MemRead,
  output logic [2:0]  dm_DMType,
  output logic [31:0] dm_Address,
  output logic [31:0] dm_Write_data,
  input  logic [31:0] dm_Read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic        OWN_A     = 1'b0;
  localparam logic        OWN_B     = 1'b1;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state;
  logic        owner;
  logic        last_owner;
  logic        l_we;
  logic [2:0]  l_type;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_legal;

  logic        win_a;
  logic        win_b;
  logic        s_we;
  logic [2:0]  s_type;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_size;
  logic [32:0] s_end;
  logic        s_legal;
  logic        in_access;
  logic [31:0] cap_data;

  // Round robin: on a tie the requester that did not win last time goes first.
  assign win_a = a_req && (!b_req || (last_owner == OWN_B));
  assign win_b = b_req && !win_a;

  // Select the winning requester's fields for latching.
  always_comb begin
    if (win_b) begin
      s_we    = b_we;
      s_type  = b_type;
      s_addr  = b_addr;
      s_wdata = b_wdata;
    end else begin
      s_we    = a_we;
      s_type  = a_type;
      s_addr  = a_addr;
      s_wdata = a_wdata;
    end
  end

  // Legality of the selected request; the end address is 33 bits so an
  // address near 2^32 cannot wrap back into range.
  always_comb begin
    case (s_type[1:0])
      2'b00:   s_size = 3'd1;
      2'b01:   s_size = 3'd2;
      default: s_size = 3'd4;
    endcase
    s_end   = {1'b0, s_addr} + {30'b0, s_size};
    s_legal = (s_type[1:0] != 2'b11) && (s_end <= MEM_LIMIT);
`ifdef DM_ARB_ALIGN_CHECK_EN
    if ((s_size == 3'd2) && s_addr[0])
      s_legal = 1'b0;
    if ((s_size == 3'd4) && (s_addr[1:0] != 2'b00))
      s_legal = 1'b0;
`endif
  end

  // Memory side is only active in ACCESS; the write strobe is also killed by
  // reset so a reset edge can never commit a half-finished store.
  assign in_access     = (state == ACCESS);
  assign dm_MemWrite   = in_access && l_legal && l_we && !rst;
  assign dm_MemRead    = in_access && l_legal && !l_we;
  assign dm_DMType     = in_access ? l_type  : 3'b000;
  assign dm_Address    = in_access ? l_addr  : 32'h0;
  assign dm_Write_data = in_access ? l_wdata : 32'h0;
  assign cap_data      = (l_legal && !l_we) ? dm_Read_data : 32'h0;

  // Sequencer FSM with registered grant/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      l_we       <= 1'b0;
      l_type     <= 3'b000;
      l_addr     <= 32'h0;
      l_wdata    <= 32'h0;
      l_legal    <= 1'b0;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      a_rdata    <= 32'h0;
      b_rdata    <= 32'h0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (win_a || win_b) begin
            owner      <= win_b;
            last_owner <= win_b;
            l_we       <= s_we;
            l_type     <= s_type;
            l_addr     <= s_addr;
            l_wdata    <= s_wdata;
            l_legal    <= s_legal;
            a_gnt      <= win_a;
            b_gnt      <= win_b;
            state      <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (owner == OWN_A) begin
            a_rvalid <= 1'b1;
            a_err    <= !l_legal;
            a_rdata  <= cap_data;
          end else begin
            b_rvalid <= 1'b1;
            b_err    <= !l_legal;
            b_rdata  <= cap_data;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: behavioural byte memory on the dm_* side plus a
// transaction-level reference memory that predicts legality and load data.
module tb_dm_arbiter;

  localparam int MB = 1024;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_type, b_type;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        dm_MemWrite, dm_MemRead;
  logic [2:0]  dm_DMType;
  logic [31:0] dm_Address, dm_Write_data, dm_Read_data;

  int n_checks;
  int n_fail;

  logic [7:0]  mem [0:MB-1];
  logic [7:0]  ref_mem [0:MB-1];
  logic        mem_clr;
  logic [31:0] rd_raw;

  dm_arbiter #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_type(a_type), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_type(b_type), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .dm_MemWrite(dm_MemWrite), .dm_MemRead(dm_MemRead), .dm_DMType(dm_DMType),
    .dm_Address(dm_Address), .dm_Write_data(dm_Write_data), .dm_Read_data(dm_Read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read with size/sign handling, write on edge.
  always_comb begin
    rd_raw = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if ({32'b0, dm_Address} + 64'(i) < 64'(MB))
        rd_raw[8*i +: 8] = mem[int'(dm_Address) + i];
    end
    case (dm_DMType)
      3'b000:  dm_Read_data = {{24{rd_raw[7]}}, rd_raw[7:0]};
      3'b001:  dm_Read_data = {{16{rd_raw[15]}}, rd_raw[15:0]};
      3'b100:  dm_Read_data = {24'h0, rd_raw[7:0]};
      3'b101:  dm_Read_data = {16'h0, rd_raw[15:0]};
      default: dm_Read_data = rd_raw;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    end else if (dm_MemWrite) begin
      for (int i = 0; i < ((dm_DMType[1:0] == 2'b00) ? 1 : (dm_DMType[1:0] == 2'b01) ? 2 : 4); i++) begin
        if ({32'b0, dm_Address} + 64'(i) < 64'(MB))
          mem[int'(dm_Address) + i] <= dm_Write_data[8*i +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] t);
    if (t[1:0] == 2'b00) return 1;
    if (t[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_legal(input logic [2:0] t, input logic [31:0] a);
    longint unsigned last;
    if (t == 3'd3 || t == 3'd7) return 1'b0;
    last = {32'b0, a} + longint'(ref_size(t));
    if (last > longint'(MB)) return 1'b0;
`ifdef DM_ARB_ALIGN_CHECK_EN
    if (ref_size(t) == 2 && (a % 2) != 0) return 1'b0;
    if (ref_size(t) == 4 && (a % 4) != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = ref_size(t);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (!t[2] && sz == 1 && v[7]) v = v | 32'hFFFFFF00;
    if (!t[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < ref_size(t); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input bit port, input bit we, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!port) begin
      a_req = 1'b1; a_we = we; a_type = typ; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_type = typ; b_addr = addr; b_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One access from an idle arbiter; entered and left just after a rising edge.
  task automatic single_access(input bit port, input bit we, input logic [2:0] typ,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bit          legal;
    logic [31:0] exp_rd;
    string       pn;
    pn     = port ? "B" : "A";
    legal  = ref_legal(typ, addr);
    exp_rd = (legal && !we) ? ref_load(typ, addr) : 32'h0;
    drive(port, we, typ, addr, wdata);
    @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL %s early_gnt: got a=%0b b=%0b want 0", pn, a_gnt, b_gnt);
    end
    n_checks++;
    if ({dm_MemWrite, dm_MemRead, dm_Address} !== 34'h0) begin
      n_fail++; $display("FAIL %s dm_idle: got we=%0b rd=%0b addr=%h want 0", pn, dm_MemWrite, dm_MemRead, dm_Address);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt} !== (port ? 2'b01 : 2'b10)) begin
      n_fail++; $display("FAIL %s gnt: got a=%0b b=%0b want owner only", pn, a_gnt, b_gnt);
    end
    n_checks++;
    if ({dm_MemWrite, dm_MemRead} !== {legal && we, legal && !we}) begin
      n_fail++; $display("FAIL %s dm_ctrl: got we=%0b rd=%0b want we=%0b rd=%0b", pn,
                         dm_MemWrite, dm_MemRead, legal && we, legal && !we);
    end
    n_checks++;
    if (dm_Address !== addr || dm_DMType !== typ) begin
      n_fail++; $display("FAIL %s dm_addr: got %h/%0d want %h/%0d", pn, dm_Address, dm_DMType, addr, typ);
    end
    if (we) begin
      n_checks++;
      if (dm_Write_data !== wdata) begin
        n_fail++; $display("FAIL %s dm_wdata: got %h want %h", pn, dm_Write_data, wdata);
      end
    end
    @(posedge clk); #1;
    if (!port) a_req = 1'b0; else b_req = 1'b0;
    if (legal && we) ref_store(typ, addr, wdata);
    @(negedge clk);
    n_checks++;
    if ({a_rvalid, b_rvalid} !== (port ? 2'b01 : 2'b10)) begin
      n_fail++; $display("FAIL %s rvalid: got a=%0b b=%0b want owner only", pn, a_rvalid, b_rvalid);
    end
    n_checks++;
    if ((port ? b_err : a_err) !== !legal) begin
      n_fail++; $display("FAIL %s err: got %0b want %0b (type %0d addr %h)", pn, port ? b_err : a_err, !legal, typ, addr);
    end
    n_checks++;
    if ((port ? b_rdata : a_rdata) !== exp_rd) begin
      n_fail++; $display("FAIL %s rdata: got %h want %h (type %0d addr %h)", pn, port ? b_rdata : a_rdata, exp_rd, typ, addr);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err});
    end
    n_checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got a=%h b=%h want 0", a_rdata, b_rdata);
    end
    n_checks++;
    if ({dm_MemWrite, dm_MemRead, dm_DMType, dm_Address, dm_Write_data} !== 69'h0) begin
      n_fail++; $display("FAIL reset_dm: got we=%0b rd=%0b type=%0d addr=%h wd=%h want 0",
                         dm_MemWrite, dm_MemRead, dm_DMType, dm_Address, dm_Write_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    single_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    single_access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
    single_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
    single_access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
  endtask

  task automatic test_boundary();
    single_access(1'b0, 1'b1, 3'b000, MB - 1, 32'h85);
    single_access(1'b1, 1'b0, 3'b000, MB - 1, 32'h0);
    single_access(1'b1, 1'b0, 3'b100, MB - 1, 32'h0);
    single_access(1'b1, 1'b0, 3'b010, MB - 2, 32'h0);
    single_access(1'b1, 1'b0, 3'b010, MB - 4, 32'h0);
    single_access(1'b0, 1'b0, 3'b011, 32'h30, 32'h0);
    single_access(1'b0, 1'b1, 3'b111, 32'h30, 32'h11111111);
    single_access(1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    single_access(1'b0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0);
  endtask

  task automatic test_align();
    single_access(1'b0, 1'b1, 3'b001, 32'h21, 32'hCAFEBABE);
    single_access(1'b0, 1'b0, 3'b101, 32'h21, 32'h0);
    single_access(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
    single_access(1'b1, 1'b0, 3'b100, 32'h22, 32'h0);
    single_access(1'b1, 1'b0, 3'b110, 32'h21, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int unsigned pick;
      logic [31:0] addr;
      pick = $urandom_range(0, 7);
      if (pick < 6)       addr = 32'($urandom_range(128, MB - 1));
      else if (pick == 6) addr = 32'(MB - 4) + 32'($urandom_range(0, 4));
      else                addr = $urandom;
      single_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), addr, $urandom);
    end
  endtask

  // Both requesters hold req for four accesses each from the reset tie state.
  task automatic test_contention();
    int order[$];
    int cyc[$];
    int a_cnt, b_cnt;
    logic [31:0] exp_a, exp_b;
    do_reset();
    exp_a = ref_load(3'b010, 32'h100);
    exp_b = ref_load(3'b010, 32'h104);
    a_cnt = 0; b_cnt = 0;
    drive(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    for (int c = 0; c < 40 && (a_cnt < 4 || b_cnt < 4); c++) begin
      @(negedge clk);
      n_checks++;
      if ((a_gnt && b_gnt) || (a_rvalid && b_rvalid)) begin
        n_fail++; $display("FAIL contention_overlap: cycle %0d gnt=%b%b rvalid=%b%b", c, a_gnt, b_gnt, a_rvalid, b_rvalid);
      end
      if (a_rvalid) begin
        n_checks++;
        if (a_rdata !== exp_a || a_err !== 1'b0) begin
          n_fail++; $display("FAIL contention_a_rdata: got %h err %0b want %h err 0", a_rdata, a_err, exp_a);
        end
      end
      if (b_rvalid) begin
        n_checks++;
        if (b_rdata !== exp_b || b_err !== 1'b0) begin
          n_fail++; $display("FAIL contention_b_rdata: got %h err %0b want %h err 0", b_rdata, b_err, exp_b);
        end
      end
      if (a_gnt) begin order.push_back(0); cyc.push_back(c); a_cnt++; end
      if (b_gnt) begin order.push_back(1); cyc.push_back(c); b_cnt++; end
      @(posedge clk); #1;
      if (a_cnt >= 4) a_req = 1'b0;
      if (b_cnt >= 4) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    n_checks++;
    if (order.size() != 8) begin
      n_fail++; $display("FAIL contention_count: got %0d grants want 8", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      n_checks++;
      if (order[i] != (i % 2) || cyc[i] != 1 + 2 * i) begin
        n_fail++; $display("FAIL contention_grant%0d: got port %0d cycle %0d want port %0d cycle %0d",
                           i, order[i], cyc[i], i % 2, 1 + 2 * i);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dm_MemWrite !== 1'b0 || a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midop_access: got MemWrite=%0b a_gnt=%0b want 0/1", dm_MemWrite, a_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, dm_MemWrite, dm_MemRead} !== 8'b0) begin
      n_fail++; $display("FAIL midop_flags: got %b want 0", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, dm_MemWrite, dm_MemRead});
    end
    n_checks++;
    if ({a_rdata, b_rdata, dm_DMType, dm_Address, dm_Write_data} !== 131'h0) begin
      n_fail++; $display("FAIL midop_data: got a=%h b=%h addr=%h wd=%h want 0", a_rdata, b_rdata, dm_Address, dm_Write_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (a_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midop_rvalid: got %0b want 0", a_rvalid);
    end
    @(posedge clk); #1;
    single_access(1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; mem_clr = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_type = 3'b000; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_type = 3'b000; b_addr = 32'h0; b_wdata = 32'h0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_boundary();
    test_align();
    test_random();
    test_contention();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
